// File: rtl/spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_arbiter
// Purpose  : Shares one SPI flash bus between two masters. Master 0 is the
//            DFU flash programmer and master 1 is a secondary reader. The bus
//            is granted to one master at a time with round-robin tie
//            breaking. While a master holds the grant, its SPI signals are
//            routed straight to the pins. Between grants the bus is parked
//            (csel high) for GUARD_CYCLES cycles.
//
// Parameters:
//   GUARD_CYCLES   - parked cycles between consecutive grants (1..255)
//   TIMEOUT_CYCLES - maximum cycles a single grant may be held (1..65535);
//                    only active when SPI_ARB_TIMEOUT_EN is defined
//
// Ports:
//   clk, reset               - system clock, async active-high reset
//   m0_req / m1_req          - bus request, held for the whole transaction
//   m0_gnt / m1_gnt          - grant, decoded from the state register
//   m0_csel/m0_sck/m0_mosi   - master 0 SPI outputs (csel active low)
//   m1_csel/m1_sck/m1_mosi   - master 1 SPI outputs (csel active low)
//   m0_miso / m1_miso        - flash data back to the granted master, else 0
//   spi_csel/spi_clk/spi_mosi- flash pins, parked as 1/0/0 when not granted
//   spi_miso                 - flash data pin
//   busy                     - high whenever the arbiter is not idle
//   timeout_err              - one-cycle pulse when the watchdog revokes
//
// Build option:
//   SPI_ARB_TIMEOUT_EN - enables the grant-hold watchdog with lockout.
//                        Undefined: grants are held indefinitely and
//                        timeout_err is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_gnt,
  output logic m1_gnt,
  input  logic m0_csel,
  input  logic m1_csel,
  input  logic m0_sck,
  input  logic m1_sck,
  input  logic m0_mosi,
  input  logic m1_mosi,
  output logic m0_miso,
  output logic m1_miso,
  output logic spi_csel,
  output logic spi_clk,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic busy,
  output logic timeout_err
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // --------------------------------------------------------------------------
  if ((GUARD_CYCLES < 1) || (GUARD_CYCLES > 255)) begin : g_bad_guard
    $error("spi_flash_arbiter: GUARD_CYCLES must be in 1..255");
  end

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("spi_flash_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT0  = 2'd1,
    S_GNT1  = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  // Guard counter counts down to 0, so it is loaded with one less than the
  // number of parked cycles wanted.
  localparam logic [7:0] c_GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;        // master granted most recently
  logic        w_last_nxt;
  logic [7:0]  r_guard_cnt;
  logic [7:0]  w_guard_cnt_nxt;

  logic        w_rel0;        // master 0 voluntarily releasing
  logic        w_rel1;        // master 1 voluntarily releasing
  logic        w_want0;       // master 0 eligible for a grant in IDLE
  logic        w_want1;       // master 1 eligible for a grant in IDLE
  logic        w_to0;         // watchdog revoking master 0
  logic        w_to1;         // watchdog revoking master 1

  // A grant is only released once the master has both dropped its request
  // and raised chip-select, so a late req drop never cuts a command short.
  assign w_rel0 = ~m0_req & m0_csel;
  assign w_rel1 = ~m1_req & m1_csel;

`ifdef SPI_ARB_TIMEOUT_EN
  // --------------------------------------------------------------------------
  // Grant-hold watchdog
  // --------------------------------------------------------------------------
  // The counter holds the number of completed cycles in the current grant.
  // Revoking when it equals TIMEOUT_CYCLES-1 makes the edge that ends the
  // TIMEOUT_CYCLES-th granted cycle the one that parks the bus.
  localparam logic [15:0] c_HOLD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_hold_cnt;
  logic        r_lock0;       // master 0 locked out after a timeout
  logic        r_lock1;       // master 1 locked out after a timeout
  logic        r_timeout_err;
  logic        w_in_gnt;
  logic        w_hold_expired;

  assign w_in_gnt       = (r_state == S_GNT0) || (r_state == S_GNT1);
  assign w_hold_expired = (r_hold_cnt == c_HOLD_LIMIT);

  // A voluntary release in the same cycle takes priority, so no error is
  // flagged for a master that finished just in time.
  assign w_to0 = (r_state == S_GNT0) && w_hold_expired && !w_rel0;
  assign w_to1 = (r_state == S_GNT1) && w_hold_expired && !w_rel1;

  assign w_want0 = m0_req & ~r_lock0;
  assign w_want1 = m1_req & ~r_lock1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt    <= '0;
      r_lock0       <= 1'b0;
      r_lock1       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // Clears whenever no grant is held, so each grant starts from zero.
      r_hold_cnt    <= w_in_gnt ? (r_hold_cnt + 16'd1) : 16'd0;
      r_timeout_err <= w_to0 | w_to1;

      // Lockout persists until the offending master drops req for a cycle.
      if (w_to0) begin
        r_lock0 <= 1'b1;
      end else if (!m0_req) begin
        r_lock0 <= 1'b0;
      end

      if (w_to1) begin
        r_lock1 <= 1'b1;
      end else if (!m1_req) begin
        r_lock1 <= 1'b0;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_to0       = 1'b0;
  assign w_to1       = 1'b0;
  assign w_want0     = m0_req;
  assign w_want1     = m1_req;
  assign timeout_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;      // master 0 wins the first tie
      r_guard_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_guard_cnt <= w_guard_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_guard_cnt_nxt = r_guard_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_want0 && w_want1) begin
          // Tie: the master not granted most recently goes first.
          w_state_nxt = r_last ? S_GNT0 : S_GNT1;
        end else if (w_want0) begin
          w_state_nxt = S_GNT0;
        end else if (w_want1) begin
          w_state_nxt = S_GNT1;
        end
      end

      S_GNT0: begin
        if (w_rel0 || w_to0) begin
          w_state_nxt     = S_GUARD;
          w_last_nxt      = 1'b0;
          w_guard_cnt_nxt = c_GUARD_LOAD;
        end
      end

      S_GNT1: begin
        if (w_rel1 || w_to1) begin
          w_state_nxt     = S_GUARD;
          w_last_nxt      = 1'b1;
          w_guard_cnt_nxt = c_GUARD_LOAD;
        end
      end

      S_GUARD: begin
        // Requests arriving here stay pending and are arbitrated in IDLE.
        if (r_guard_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_guard_cnt_nxt = r_guard_cnt - 8'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Grants come straight from the state register: no path from req to gnt,
  // and an asynchronous reset drops them without waiting for a clock edge.
  assign m0_gnt = (r_state == S_GNT0);
  assign m1_gnt = (r_state == S_GNT1);
  assign busy   = (r_state != S_IDLE);

  // Pin routing is purely combinational so the SPI path adds no latency.
  always_comb begin
    spi_csel = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    m0_miso  = 1'b0;
    m1_miso  = 1'b0;

    case (r_state)
      S_GNT0: begin
        spi_csel = m0_csel;
        spi_clk  = m0_sck;
        spi_mosi = m0_mosi;
        m0_miso  = spi_miso;
      end
      S_GNT1: begin
        spi_csel = m1_csel;
        spi_clk  = m1_sck;
        spi_mosi = m1_mosi;
        m1_miso  = spi_miso;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_arbiter
// Purpose  : Self-checking bench for spi_flash_arbiter. Directed scenarios
//            followed by randomized two-master traffic, all compared every
//            cycle against a behavioural model of owner / guard gap / last.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_arbiter;

  localparam int GUARD = 4;
  localparam int TMO   = 100;

  logic clk = 1'b0;
  logic reset;
  logic m0_req, m1_req, m0_gnt, m1_gnt;
  logic m0_csel, m1_csel, m0_sck, m1_sck, m0_mosi, m1_mosi;
  logic m0_miso, m1_miso;
  logic spi_csel, spi_clk, spi_mosi, spi_miso;
  logic busy, timeout_err;

  always #5 clk = ~clk;

  spi_flash_arbiter #(
    .GUARD_CYCLES   (GUARD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_req      (m0_req),
    .m1_req      (m1_req),
    .m0_gnt      (m0_gnt),
    .m1_gnt      (m1_gnt),
    .m0_csel     (m0_csel),
    .m1_csel     (m1_csel),
    .m0_sck      (m0_sck),
    .m1_sck      (m1_sck),
    .m0_mosi     (m0_mosi),
    .m1_mosi     (m1_mosi),
    .m0_miso     (m0_miso),
    .m1_miso     (m1_miso),
    .spi_csel    (spi_csel),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Drive values per master, copied onto the DUT pins by apply().
  logic d_req[2], d_cs[2], d_sck[2], d_mosi[2];

  // Reference model: who owns the bus (-1 none), parked cycles still to run,
  // who went last, how long the current grant has lasted, lockout flags.
  int   owner, gap, last, hold;
  logic lock[2];
  logic exp_terr;

  // Random master phases: 0 idle, 1 waiting, 2 transferring, 3 finishing.
  int ph[2];
  int len[2];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic apply();
    m0_req  = d_req[0];  m1_req  = d_req[1];
    m0_csel = d_cs[0];   m1_csel = d_cs[1];
    m0_sck  = d_sck[0];  m1_sck  = d_sck[1];
    m0_mosi = d_mosi[0]; m1_mosi = d_mosi[1];
  endtask

  task automatic model_reset();
    owner = -1; gap = 0; last = 1; hold = 0;
    lock[0] = 1'b0; lock[1] = 1'b0; exp_terr = 1'b0;
  endtask

  task automatic set_m(input int i, input logic rq, input logic cs,
                       input logic sk, input logic mo);
    d_req[i] = rq; d_cs[i] = cs; d_sck[i] = sk; d_mosi[i] = mo;
  endtask

  task automatic check_outputs();
    logic e_csel, e_clk, e_mosi;
    e_csel = 1'b1; e_clk = 1'b0; e_mosi = 1'b0;
    if (owner >= 0) begin
      e_csel = d_cs[owner]; e_clk = d_sck[owner]; e_mosi = d_mosi[owner];
    end
    chk("m0_gnt", m0_gnt, owner == 0);
    chk("m1_gnt", m1_gnt, owner == 1);
    chk("busy", busy, (owner >= 0) || (gap > 0));
    chk("spi_csel", spi_csel, e_csel);
    chk("spi_clk", spi_clk, e_clk);
    chk("spi_mosi", spi_mosi, e_mosi);
    chk("m0_miso", m0_miso, (owner == 0) ? spi_miso : 1'b0);
    chk("m1_miso", m1_miso, (owner == 1) ? spi_miso : 1'b0);
    chk("timeout_err", timeout_err, exp_terr);
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    logic lk[2];
    int   w;
    exp_terr = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    lk = lock;
    for (int i = 0; i < 2; i++) if (!d_req[i]) lock[i] = 1'b0;
    if (owner >= 0) begin
      hold++;
      if (!d_req[owner] && d_cs[owner]) begin
        last = owner; owner = -1; gap = GUARD;
      end
`ifdef SPI_ARB_TIMEOUT_EN
      else if (hold == TMO) begin
        lock[owner] = 1'b1; exp_terr = 1'b1;
        last = owner; owner = -1; gap = GUARD;
      end
`endif
    end else if (gap > 0) begin
      gap--;
    end else begin
      w = -1;
      if (d_req[0] && !lk[0] && d_req[1] && !lk[1]) w = 1 - last;
      else if (d_req[0] && !lk[0]) w = 0;
      else if (d_req[1] && !lk[1]) w = 1;
      if (w >= 0) begin owner = w; hold = 0; end
    end
  endtask

  task automatic tick();
    apply();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  function automatic int dut_owner();
    return m0_gnt ? 0 : (m1_gnt ? 1 : -1);
  endfunction

  task automatic rand_master(input int i);
    case (ph[i])
      0: begin
        set_m(i, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        if ($urandom_range(0, 3) == 0) begin d_req[i] = 1'b1; ph[i] = 1; end
      end
      1: begin
        if (owner == i) begin
          set_m(i, 1'b1, 1'b0, 1'b0, 1'($urandom));
          len[i] = int'($urandom_range(1, 12));
          ph[i] = 2;
        end else begin
          set_m(i, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        end
      end
      2: begin
        d_sck[i] = ~d_sck[i]; d_mosi[i] = 1'($urandom);
        if ($urandom_range(0, 5) == 0) d_req[i] = 1'b0;
        len[i]--;
        if (len[i] <= 0) ph[i] = 3;
      end
      default: begin
        d_cs[i] = 1'b1; d_sck[i] = 1'b0;
        if ($urandom_range(0, 1) == 0) d_req[i] = 1'b0;
        if (!d_req[i]) ph[i] = 0;
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, who, gnt_cnt;
    reset = 1'b1; spi_miso = 1'b0;
    for (int i = 0; i < 2; i++) begin set_m(i, 1'b0, 1'b1, 1'b0, 1'b0); ph[i] = 0; len[i] = 0; end
    model_reset();
    tick(); tick();
    reset = 1'b0;

    // ---- Both masters request together straight out of reset ----
    d_req[0] = 1'b1; d_req[1] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (dut_owner() < 0 && n < 20) begin tick(); n++; end
      who = dut_owner();
      chk_int("rr_order", who, t % 2);
      if (t > 0) chk_int("rr_gap", n, GUARD + 1);
      if (who >= 0) begin
        d_cs[who] = 1'b0;
        for (int k = 0; k < 3; k++) begin d_sck[who] = ~d_sck[who]; tick(); end
        set_m(who, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rr_release", (m0_gnt | m1_gnt), 1'b0);
        d_req[who] = (t < 2);
      end
    end
    d_req[0] = 1'b0; d_req[1] = 1'b0;
    repeat (GUARD + 2) tick();

    // ---- Single master: latency, zero-delay pin path, pending m1 ----
    d_req[0] = 1'b1;
    tick();
    chk("m0_latency", m0_gnt, 1'b1);
    set_m(1, 1'b1, 1'b0, 1'b1, 1'b1);
    d_cs[0] = 1'b0; spi_miso = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d_sck[0] = ~d_sck[0]; d_mosi[0] = 1'($urandom);
      apply(); #1;
      chk("sck_zero_delay", spi_clk, d_sck[0]);
      chk("m1_miso_isolated", m1_miso, 1'b0);
      tick();
    end
    d_req[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_csel_low", m0_gnt, 1'b1);
    end
    d_cs[0] = 1'b1; d_sck[0] = 1'b0;
    tick();
    chk("release_after_csel", m0_gnt, 1'b0);
    n = 0;
    while (!m1_gnt && n < 20) begin tick(); n++; end
    chk_int("m1_after_release", n, GUARD + 1);
    set_m(1, 1'b0, 1'b1, 1'b0, 1'b0);
    spi_miso = 1'b0;
    repeat (GUARD + 2) tick();

    // ---- Asynchronous reset in the middle of a master-0 transfer ----
    d_req[0] = 1'b1;
    tick();
    set_m(0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_gnt", m0_gnt, 1'b0);
    chk("rst_csel", spi_csel, 1'b1);
    chk("rst_clk", spi_clk, 1'b0);
    chk("rst_busy", busy, 1'b0);
    set_m(0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // ---- Long hold with chip-select low ----
    d_req[0] = 1'b1;
    tick();
    d_cs[0] = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    n = 1;
    while (m0_gnt && n < TMO + 20) begin tick(); n++; end
    chk_int("timeout_hold_len", n, TMO + 1);
    chk("timeout_pulse", timeout_err, 1'b1);
    repeat (20) tick();
    chk("lockout", m0_gnt, 1'b0);
    d_req[0] = 1'b0; d_cs[0] = 1'b1;
    tick();
    d_req[0] = 1'b1;
    n = 0;
    while (!m0_gnt && n < 20) begin tick(); n++; end
    chk("regrant_after_drop", m0_gnt, 1'b1);
`else
    gnt_cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (m0_gnt) gnt_cnt++;
    end
    chk_int("hold_1000", gnt_cnt, 1000);
    chk("no_timeout", timeout_err, 1'b0);
`endif
    set_m(0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (GUARD + 2) tick();

    // ---- Randomized two-master traffic ----
    for (int k = 0; k < 3000; k++) begin
      rand_master(0);
      rand_master(1);
      spi_miso = 1'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
